fibonacci_inv: RTL and testbench
================================

FIBONACCI_INV -- requirements
Module: fibonacci_inv

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bit width of the input value.
REQ-002 Parameter IDX_WIDTH, default 4, bit width of the index output; shall hold the largest reachable index (14 for DATA_WIDTH=8).
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 value  input  DATA_WIDTH  number to decode; sampled with accepted start.
REQ-007 busy  output  1  high whenever state != IDLE.
REQ-008 valid  output  1  one-cycle pulse; is_fib/index are final.
REQ-009 is_fib  output  1  1 = latched value is a Fibonacci number.
REQ-010 index  output  IDX_WIDTH  smallest n with F(n) = value when is_fib=1, else 0.

Function
REQ-011 Sequence definition: F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2); a value of 1 shall report index 1, the smallest n.
REQ-012 States: IDLE, SEARCH, DONE; all outputs shall be registered.
REQ-013 IDLE: on start=1, the block shall latch value into target, load a=F(0)=0, b=F(1)=1, idx=0, and enter SEARCH; otherwise it shall stay in IDLE.
REQ-014 a and b shall be DATA_WIDTH+2 bits wide internally so that a+b never wraps before the search terminates.
REQ-015 Each SEARCH cycle, when a == target: is_fib<=1, index<=idx, go to DONE.
REQ-016 Each SEARCH cycle, when a > target: is_fib<=0, index<=0, go to DONE.
REQ-017 Each SEARCH cycle, when a < target: a<=b, b<=a+b, idx<=idx+1, stay in SEARCH.
REQ-018 DONE shall last exactly one cycle with valid=1, then go to IDLE unconditionally.
REQ-019 Latency: with start accepted at edge of cycle 0, valid shall be high in cycle N+2, where N is idx at termination; maximum N=14 for DATA_WIDTH=8.
REQ-020 start while busy=1, including in DONE, shall be ignored, and value changes while busy shall not affect the result.
REQ-021 Back-to-back: start asserted in the first IDLE cycle after DONE shall be accepted.
REQ-022 is_fib and index shall hold their last result until the next result is written; they shall not be cleared on start.
REQ-023 valid shall be 0 in every state except DONE.

Reset
REQ-024 rst=1 shall force state=IDLE, busy=0, valid=0, is_fib=0, index=0, a=0, b=1, idx=0, target=0 at the next edge.
REQ-025 rst asserted during SEARCH or DONE shall abort the operation with no valid pulse; rst has priority over start.
REQ-026 After rst is deasserted, the first start shall be accepted normally.

Verification
REQ-027 value=0, start 1 cycle -> valid in cycle 2, is_fib=1, index=0, busy high cycles 1-2.
REQ-028 value=1 -> valid in cycle 3, is_fib=1, index=1; value=233 -> valid in cycle 15, is_fib=1, index=13.
REQ-029 value=4 -> valid in cycle 7 (terminates at a=5), is_fib=0, index=0; value=255 -> valid in cycle 16, is_fib=0, index=0.
REQ-030 value=8 with start held high throughout and value toggled during SEARCH -> exactly one valid per accepted start; first result is_fib=1, index=6; a new request is accepted in the IDLE cycle after DONE.
REQ-031 rst pulsed in cycle 5 of a value=144 search -> no valid pulse, all outputs 0 next cycle; a following value=144 request -> is_fib=1, index=12, valid in cycle 14.
REQ-032 Exhaustive sweep of value 0..255 against a reference model -> is_fib/index match and latency = N+2 for every value.

Source files
------------

// File: rtl/fibonacci_inv_if.sv
// Request/result bundle for the inverse-Fibonacci decoder.
interface fibonacci_inv_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 4
);
  logic                  start_i;
  logic [DATA_WIDTH-1:0] value_i;
  logic                  busy_o;
  logic                  valid_o;
  logic                  is_fib_o;
  logic [IDX_WIDTH-1:0]  index_o;

  modport slave (
    input  start_i, value_i,
    output busy_o, valid_o, is_fib_o, index_o
  );

  modport master (
    output start_i, value_i,
    input  busy_o, valid_o, is_fib_o, index_o
  );
endinterface

// File: rtl/fibonacci_inv.sv
// Decides whether a value is a Fibonacci number and, if so, returns its smallest index
// by walking the sequence one term per cycle.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// SEARCH | stepping a/b through the sequence until a >= target
// DONE   | one-cycle valid pulse, then back to IDLE
module fibonacci_inv #(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 4
) (
  input  logic            clk,
  input  logic            rst,
  fibonacci_inv_if.slave  bus
);

  localparam int AB_WIDTH = DATA_WIDTH + 2;
  localparam logic [AB_WIDTH-1:0]  AB_ONE  = 1;
  localparam logic [IDX_WIDTH-1:0] IDX_ONE = 1;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                state_q;
  logic [AB_WIDTH-1:0]   a_q, b_q;
  logic [AB_WIDTH-1:0]   sum_d;
  logic [AB_WIDTH-1:0]   target_ext;
  logic [DATA_WIDTH-1:0] target_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic                  busy_q, valid_q, is_fib_q;
  logic [IDX_WIDTH-1:0]  index_q;

  assign sum_d      = a_q + b_q;
  assign target_ext = {2'b00, target_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= AB_ONE;
      idx_q    <= '0;
      target_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      is_fib_q <= 1'b0;
      index_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.start_i) begin
            target_q <= bus.value_i;
            a_q      <= '0;
            b_q      <= AB_ONE;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SEARCH;
          end
        end
        SEARCH: begin
          if (a_q == target_ext) begin
            is_fib_q <= 1'b1;
            index_q  <= idx_q;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else if (a_q > target_ext) begin
            is_fib_q <= 1'b0;
            index_q  <= '0;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else begin
            a_q   <= b_q;
            b_q   <= sum_d;
            idx_q <= idx_q + IDX_ONE;
          end
        end
        DONE: begin
          // start is deliberately ignored here; a new request needs one IDLE cycle
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.valid_o  = valid_q;
  assign bus.is_fib_o = is_fib_q;
  assign bus.index_o  = index_q;

endmodule

// File: tb/tb_fibonacci_inv.sv
// Directed and exhaustive checks of the inverse-Fibonacci decoder.
module tb_fibonacci_inv;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  fibonacci_inv_if #(.DATA_WIDTH(8), .IDX_WIDTH(4)) bus_if ();

  fibonacci_inv #(.DATA_WIDTH(8), .IDX_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void ref_model(input int v, output logic f, output logic [3:0] ix,
                                    output int n);
    int a, b, t;
    a = 0; b = 1; n = 0;
    while (a < v) begin
      t = a + b; a = b; b = t; n++;
    end
    f  = (a == v);
    ix = f ? n[3:0] : 4'd0;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after DONE.
  task automatic do_req(input string tag, input logic [7:0] v, input logic ef,
                        input logic [3:0] ei, input int elat);
    int lat;
    bit busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    bus_if.start_i = 1'b1;
    bus_if.value_i = v;
    @(posedge clk);
    #1;
    bus_if.start_i = 1'b0;
    bus_if.value_i = ~v;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (bus_if.valid_o) lat = c;
      else if (!bus_if.busy_o) busy_ok = 1'b0;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_isfib"}, bus_if.is_fib_o, ef);
    check({tag, "_index"}, bus_if.index_o, ei);
    check({tag, "_busy_done"}, bus_if.busy_o, 1);
    check({tag, "_busy_search"}, busy_ok, 1);
    @(negedge clk);
    check({tag, "_pulse"}, bus_if.valid_o, 0);
    check({tag, "_idle"}, bus_if.busy_o, 0);
  endtask

  initial begin
    logic       f;
    logic [3:0] ix;
    int         n, nvalid, first_cyc, second_cyc;

    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1;
    bus_if.start_i = 1'b0;
    bus_if.value_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus_if.busy_o, 0);
    check("rst_valid", bus_if.valid_o, 0);
    check("rst_isfib", bus_if.is_fib_o, 0);
    check("rst_index", bus_if.index_o, 0);
    rst = 1'b0;

    do_req("v0", 8'd0, 1'b1, 4'd0, 2);
    do_req("v1", 8'd1, 1'b1, 4'd1, 3);
    do_req("v233", 8'd233, 1'b1, 4'd13, 15);
    do_req("v4", 8'd4, 1'b0, 4'd0, 7);
    do_req("v255", 8'd255, 1'b0, 4'd0, 16);
    do_req("v2", 8'd2, 1'b1, 4'd3, 5);

    // Abort a search mid-way; previous result (233) must be wiped by reset.
    do_req("pre_rst", 8'd233, 1'b1, 4'd13, 15);
    bus_if.start_i = 1'b1;
    bus_if.value_i = 8'd144;
    @(posedge clk);
    #1;
    bus_if.start_i = 1'b0;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", bus_if.busy_o, 0);
    check("abort_valid", bus_if.valid_o, 0);
    check("abort_isfib", bus_if.is_fib_o, 0);
    check("abort_index", bus_if.index_o, 0);
    rst = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_if.valid_o) nvalid++;
    end
    check("abort_no_valid", nvalid, 0);
    do_req("post_rst", 8'd144, 1'b1, 4'd12, 14);

    // start held high, value toggled while busy, second request taken right after DONE.
    nvalid = 0; first_cyc = 0; second_cyc = 0;
    bus_if.start_i = 1'b1;
    bus_if.value_i = 8'd8;
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus_if.valid_o) begin
        nvalid++;
        if (nvalid == 1) begin
          first_cyc = c;
          check("b2b_first_isfib", bus_if.is_fib_o, 1);
          check("b2b_first_index", bus_if.index_o, 6);
          bus_if.value_i = 8'd13;
        end else begin
          second_cyc = c;
          check("b2b_second_isfib", bus_if.is_fib_o, 1);
          check("b2b_second_index", bus_if.index_o, 7);
        end
      end else if (nvalid == 0) begin
        bus_if.value_i = (c % 2 == 1) ? 8'hFF : 8'h00;
      end
      if (c == 9) check("b2b_idle_gap", bus_if.busy_o, 0);
      if (c == 10) begin
        check("b2b_accept", bus_if.busy_o, 1);
        bus_if.start_i = 1'b0;
      end
    end
    check("b2b_first_cyc", first_cyc, 8);
    check("b2b_second_cyc", second_cyc, 18);
    check("b2b_count", nvalid, 2);

    for (int v = 0; v < 256; v++) begin
      ref_model(v, f, ix, n);
      do_req($sformatf("sweep%0d", v), v[7:0], f, ix, n + 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
